crt_mode_detect: RTL and testbench

//  Sequencer for the crt_measure unit. Repeatedly measures the hsync period in clk
//  (mode 0), then lines per frame in hsync (mode 1). Compares successive pairs;

---
 rtl/crt_mode_detect.sv | 161 ++++++++++++++++
 tb/tb_crt_mode_detect.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crt_mode_detect.sv
// Sequencer for the crt_measure unit: alternates hsync-period and lines-per-frame
// measurements, compares successive pairs and reports a locked video mode or sync loss.
module crt_mode_detect #(
  parameter int W            = 10,
  parameter int STABLE_COUNT = 4,
  parameter int TOL          = 2,
  parameter int TIMEOUT      = 2000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  output logic         meas_start,
  output logic         meas_mode,
  input  logic         meas_busy,
  input  logic [W-1:0] meas_q,
  output logic [W-1:0] hperiod,
  output logic [W-1:0] vlines,
  output logic         locked,
  output logic         no_signal,
  output logic         mode_change
);

  // state   | meaning
  // IDLE    | loop stopped, waiting for enable
  // H_START | start pulse issued, mode 0 (hsync period in clk)
  // H_ARM   | waiting for measure unit to report busy
  // H_WAIT  | waiting for busy to drop, then capture new_h
  // V_START | start pulse issued, mode 1 (frame length in lines)
  // V_ARM   | waiting for measure unit to report busy
  // V_WAIT  | waiting for busy to drop, then capture new_v
  // EVAL    | compare new pair against previous pair, update lock
  typedef enum logic [2:0] {
    IDLE, H_START, H_ARM, H_WAIT, V_START, V_ARM, V_WAIT, EVAL
  } state_t;

  localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   T_LOAD = TW'(TIMEOUT - 1);
  localparam logic [W:0]      TOL_W  = (W + 1)'(TOL);
  localparam logic [3:0]      SC_MAX = 4'(STABLE_COUNT);
  localparam logic [3:0]      SC_LAST = 4'(STABLE_COUNT - 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [3:0]    stable_cnt;
  logic [W-1:0]  prev_h, prev_v, new_h, new_v;

  logic [W:0] diff_h, diff_v;
  logic       match, q_bad, in_arm, in_wait, expired, abort;

  assign diff_h  = (new_h >= prev_h) ? ({1'b0, new_h} - {1'b0, prev_h})
                                     : ({1'b0, prev_h} - {1'b0, new_h});
  assign diff_v  = (new_v >= prev_v) ? ({1'b0, new_v} - {1'b0, prev_v})
                                     : ({1'b0, prev_v} - {1'b0, new_v});
  assign match   = (diff_h <= TOL_W) && (diff_v <= TOL_W);
  assign q_bad   = (meas_q == '0) || (meas_q == '1);
  assign in_arm  = (state == H_ARM) || (state == V_ARM);
  assign in_wait = (state == H_WAIT) || (state == V_WAIT);
  assign expired = (tcnt == '0);
  // A capture that completes on the last allowed cycle still counts as valid.
  assign abort   = (in_arm && !meas_busy && expired) ||
                   (in_wait && meas_busy && expired) ||
                   (in_wait && !meas_busy && q_bad);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      meas_start  <= 1'b0;
      meas_mode   <= 1'b0;
      hperiod     <= '0;
      vlines      <= '0;
      locked      <= 1'b0;
      no_signal   <= 1'b0;
      mode_change <= 1'b0;
      stable_cnt  <= '0;
      prev_h      <= '0;
      prev_v      <= '0;
      new_h       <= '0;
      new_v       <= '0;
      tcnt        <= '0;
    end else begin
      meas_start  <= 1'b0;
      mode_change <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        locked      <= 1'b0;
        stable_cnt  <= '0;
        mode_change <= locked;
      end else if (abort) begin
        // prev is cleared so the first pair after sync loss never counts as a match
        no_signal   <= 1'b1;
        locked      <= 1'b0;
        stable_cnt  <= '0;
        mode_change <= locked;
        prev_h      <= '0;
        prev_v      <= '0;
        state       <= H_START;
        meas_start  <= 1'b1;
        meas_mode   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= H_START;
            meas_start <= 1'b1;
            meas_mode  <= 1'b0;
          end
          H_START: begin
            tcnt  <= T_LOAD;
            state <= H_ARM;
          end
          V_START: begin
            tcnt  <= T_LOAD;
            state <= V_ARM;
          end
          H_ARM, V_ARM: begin
            if (meas_busy) state <= (state == H_ARM) ? H_WAIT : V_WAIT;
            if (!expired) tcnt <= tcnt - 1'b1;
          end
          H_WAIT: begin
            if (!meas_busy) begin
              new_h      <= meas_q;
              state      <= V_START;
              meas_start <= 1'b1;
              meas_mode  <= 1'b1;
            end
            if (!expired) tcnt <= tcnt - 1'b1;
          end
          V_WAIT: begin
            if (!meas_busy) begin
              new_v <= meas_q;
              state <= EVAL;
            end
            if (!expired) tcnt <= tcnt - 1'b1;
          end
          EVAL: begin
            // stable_cnt counts consecutive matching pairs
            if (match) begin
              if (stable_cnt < SC_MAX) stable_cnt <= stable_cnt + 1'b1;
              if (stable_cnt >= SC_LAST) begin
                locked  <= 1'b1;
                hperiod <= new_h;
                vlines  <= new_v;
              end
            end else begin
              stable_cnt  <= '0;
              locked      <= 1'b0;
              mode_change <= locked;
            end
            prev_h     <= new_h;
            prev_v     <= new_v;
            no_signal  <= 1'b0;
            state      <= H_START;
            meas_start <= 1'b1;
            meas_mode  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crt_mode_detect.sv
// Bench for crt_mode_detect: plays the measure unit and checks lock/sync-loss
// outputs against a pair-history model at every hsync measurement start.
module tb_crt_mode_detect;
  localparam int W   = 10;
  localparam int SC  = 4;
  localparam int TOL = 2;
  localparam int TO  = 64;
  localparam int QMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         meas_busy = 1'b0;
  logic [W-1:0] meas_q = '0;
  logic         meas_start, meas_mode, locked, no_signal, mode_change;
  logic [W-1:0] hperiod, vlines;

  crt_mode_detect #(.W(W), .STABLE_COUNT(SC), .TOL(TOL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .meas_start(meas_start), .meas_mode(meas_mode),
    .meas_busy(meas_busy), .meas_q(meas_q),
    .hperiod(hperiod), .vlines(vlines),
    .locked(locked), .no_signal(no_signal), .mode_change(mode_change)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mc_seen = 0;
  bit have_start = 0;

  // model: history of match results since the last reset/abort/disable
  int m_prev_h, m_prev_v, m_hp, m_vl, m_mc;
  bit m_locked, m_ns;
  bit hist[$];

  function automatic int iabs(int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit is_bad(int q);
    return (q == 0) || (q == QMAX);
  endfunction

  function automatic void model_reset();
    m_prev_h = 0; m_prev_v = 0; m_hp = 0; m_vl = 0;
    m_locked = 0; m_ns = 0; hist.delete();
  endfunction

  function automatic void model_lost();
    if (m_locked) m_mc++;
    m_locked = 0;
  endfunction

  function automatic void model_abort();
    m_ns = 1; m_prev_h = 0; m_prev_v = 0; hist.delete();
    model_lost();
  endfunction

  function automatic void model_disable();
    hist.delete();
    model_lost();
  endfunction

  function automatic void model_eval(int h, int v);
    bit run;
    hist.push_back((iabs(h - m_prev_h) <= TOL) && (iabs(v - m_prev_v) <= TOL));
    m_prev_h = h; m_prev_v = v; m_ns = 0;
    run = (hist.size() >= SC);
    for (int i = 0; i < SC && run; i++)
      if (!hist[hist.size() - 1 - i]) run = 0;
    if (run) begin
      m_locked = 1; m_hp = h; m_vl = v;
    end else begin
      model_lost();
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle protocol invariants
  initial begin
    bit prev_ms, prev_mc, prev_en;
    prev_ms = 0; prev_mc = 0; prev_en = 0;
    forever begin
      @(negedge clk);
      if (mode_change) mc_seen++;
      checks++;
      if (locked && no_signal) begin
        errors++; $display("FAIL locked_and_no_signal actual=1 required=0 at %0t", $time);
      end
      if (prev_mc && mode_change) begin
        errors++; $display("FAIL mode_change_width actual=2 required=1 at %0t", $time);
      end
      if (prev_ms && meas_start) begin
        errors++; $display("FAIL meas_start_width actual=2 required=1 at %0t", $time);
      end
      if (!prev_en && !enable && meas_start) begin
        errors++; $display("FAIL start_while_disabled actual=1 required=0 at %0t", $time);
      end
      prev_ms = meas_start; prev_mc = mode_change; prev_en = enable;
    end
  end

  task automatic wait_start(output bit ok, output int mode, output int cyc);
    ok = 0; mode = 0; cyc = 0;
    while (!ok && cyc < TO + 40) begin
      @(negedge clk);
      cyc++;
      if (meas_start) begin
        ok = 1; mode = int'(meas_mode);
      end
    end
  endtask

  task automatic sync_start();
    bit ok; int mode, cyc;
    if (!have_start) begin
      wait_start(ok, mode, cyc);
      chk("h_start_seen", ok, 1);
      chk("h_start_mode", mode, 0);
      have_start = 1;
    end
    #1;
  endtask

  task automatic check_model();
    #1;
    chk("locked", locked, m_locked);
    chk("no_signal", no_signal, m_ns);
    chk("hperiod", hperiod, m_hp);
    chk("vlines", vlines, m_vl);
    chk("mode_change_count", mc_seen, m_mc);
  endtask

  // stall: 0 none, 1 never busy, 2 busy never drops; used = negedges consumed
  task automatic respond(input int val, input int stall, input int exp_mode, output int used);
    used = 0;
    if (stall == 1) return;
    if (stall == 2) begin
      @(negedge clk); used = 1; meas_busy = 1'b1;
      return;
    end
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk); chk("mode_hold", meas_mode, exp_mode);
    end
    meas_busy = 1'b1; meas_q = W'($urandom);
    repeat ($urandom_range(1, 5)) begin
      @(negedge clk); chk("mode_hold", meas_mode, exp_mode);
      meas_q = W'($urandom);
    end
    meas_busy = 1'b0; meas_q = W'(val);
  endtask

  task automatic timeout_tail(input int used);
    bit ok; int mode, cyc;
    model_abort();
    wait_start(ok, mode, cyc);
    meas_busy = 1'b0;
    chk("timeout_restart", ok, 1);
    chk("timeout_cycles", cyc + used, TO + 1);
    chk("timeout_mode", mode, 0);
    have_start = ok;
  endtask

  task automatic do_pair(input int h, input int hs, input int v, input int vs);
    bit ok; int mode, cyc, used;
    sync_start();
    check_model();
    have_start = 0;
    respond(h, hs, 0, used);
    if (hs != 0) begin timeout_tail(used); return; end
    if (is_bad(h)) begin model_abort(); return; end
    wait_start(ok, mode, cyc);
    chk("v_start_seen", ok, 1);
    chk("v_start_mode", mode, 1);
    respond(v, vs, 1, used);
    if (vs != 0) timeout_tail(used);
    else if (is_bad(v)) model_abort();
    else model_eval(h, v);
  endtask

  initial begin
    int bh, bv, h, v, hs, vs, k, used, mc0;
    bit ok; int mode, cyc;
    model_reset();
    m_mc = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_no_signal", no_signal, 0);
    chk("rst_hperiod", hperiod, 0);
    chk("rst_vlines", vlines, 0);
    chk("rst_meas_start", meas_start, 0);
    chk("rst_mode_change", mode_change, 0);
    reset = 1'b0;
    enable = 1'b1;

    // constant 800/525: lock on the fifth evaluation
    repeat (4) do_pair(800, 0, 525, 0);
    sync_start();
    chk("t1_not_locked_after4", locked, 0);
    do_pair(800, 0, 525, 0);
    sync_start();
    chk("t1_locked", locked, 1);
    chk("t1_hperiod", hperiod, 800);
    chk("t1_vlines", vlines, 525);
    chk("t1_no_signal", no_signal, 0);

    // jitter within tolerance keeps lock and tracks latest values
    do_pair(802, 0, 525, 0);
    do_pair(800, 0, 525, 0);
    do_pair(802, 0, 526, 0);
    sync_start();
    chk("t2_locked", locked, 1);
    chk("t2_hperiod", hperiod, 802);
    chk("t2_vlines", vlines, 526);
    chk("t2_mode_change", mc_seen, 0);

    // mode switch: one pulse, relock five evaluations later
    do_pair(640, 0, 262, 0);
    sync_start();
    chk("t3_unlocked", locked, 0);
    chk("t3_pulse", mc_seen, 1);
    repeat (4) do_pair(640, 0, 262, 0);
    sync_start();
    chk("t3_relocked", locked, 1);
    chk("t3_hperiod", hperiod, 640);
    chk("t3_vlines", vlines, 262);
    chk("t3_pulse_once", mc_seen, 1);

    // vsync stops while locked
    do_pair(640, 0, 0, 1);
    sync_start();
    chk("t4_no_signal", no_signal, 1);
    chk("t4_locked", locked, 0);
    chk("t4_pulse", mc_seen, 2);
    do_pair(640, 0, 262, 0);
    sync_start();
    chk("t4_restored", no_signal, 0);

    // overflow capture aborts, relock needs a full fresh run
    do_pair(QMAX, 0, 0, 0);
    sync_start();
    chk("t5_no_signal", no_signal, 1);
    repeat (4) do_pair(640, 0, 262, 0);
    sync_start();
    chk("t5_not_locked_after4", locked, 0);
    do_pair(640, 0, 262, 0);
    sync_start();
    chk("t5_locked", locked, 1);

    // randomized pairs
    bh = 800; bv = 525;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 99);
      if (k < 10) begin bh = 640; bv = 262; end
      else if (k < 20) begin bh = 800; bv = 525; end
      else if (k < 25) begin bh = $urandom_range(100, 1000); bv = $urandom_range(100, 1000); end
      if ($urandom_range(0, 3) != 0) begin
        h = bh + int'($urandom_range(0, 2 * TOL)) - TOL;
        v = bv + int'($urandom_range(0, 2 * TOL)) - TOL;
      end else begin
        h = bh + int'($urandom_range(0, 2 * TOL + 6)) - (TOL + 3);
        v = bv + int'($urandom_range(0, 2 * TOL + 6)) - (TOL + 3);
      end
      hs = 0; vs = 0;
      k = $urandom_range(0, 99);
      if (k < 3) hs = $urandom_range(1, 2);
      else if (k < 6) vs = $urandom_range(1, 2);
      else if (k < 10) h = ($urandom_range(0, 1) != 0) ? QMAX : 0;
      else if (k < 14) v = ($urandom_range(0, 1) != 0) ? QMAX : 0;
      do_pair(h, hs, v, vs);
    end

    // drop enable mid-H_WAIT
    repeat (5) do_pair(800, 0, 525, 0);
    sync_start();
    chk("t6_locked_before", locked, 1);
    check_model();
    have_start = 0;
    mc0 = mc_seen;
    @(negedge clk); meas_busy = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    model_disable();
    repeat (20) @(negedge clk);
    meas_busy = 1'b0;
    repeat (5) @(negedge clk);
    check_model();
    chk("t6_disable_locked", locked, 0);
    chk("t6_disable_pulse", mc_seen, mc0 + 1);
    chk("t6_disable_hperiod", hperiod, 800);
    enable = 1'b1;
    repeat (2) do_pair(800, 0, 525, 0);

    // reset mid-V_ARM
    sync_start();
    check_model();
    have_start = 0;
    respond(800, 0, 0, used);
    wait_start(ok, mode, cyc);
    chk("t6_v_start", ok, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    #1;
    chk("t6_rst_locked", locked, 0);
    chk("t6_rst_no_signal", no_signal, 0);
    chk("t6_rst_hperiod", hperiod, 0);
    chk("t6_rst_vlines", vlines, 0);
    chk("t6_rst_meas_start", meas_start, 0);
    chk("t6_rst_meas_mode", meas_mode, 0);
    chk("t6_rst_mode_change", mode_change, 0);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
